uart_rx_port: RTL
=================

UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
- REQ-001: Parameter BAUD_DIV, default 326, is the clock cycles per 16x oversample tick (50 MHz, 9600 baud).
- REQ-002: Port clk, input, 1, system clock; all state changes on its rising edge.
- REQ-003: Port reset, input, 1, synchronous, active-high reset.
- REQ-004: Port rx, input, 1, asynchronous serial line; idle high; 8N1 frames, LSB first.
- REQ-005: Port cs, input, 1, chip select from the processor port decode.
- REQ-006: Port read_strobe, input, 1, processor read strobe; a read is cs AND read_strobe in the same cycle.
- REQ-007: Port data_out, output, 8, last accepted byte.
- REQ-008: Port rx_ready, output, 1, unread byte held in data_out.
- REQ-009: Port overrun, output, 1, a valid frame arrived while rx_ready was set.
- REQ-010: Port framing_err, output, 1, last frame had stop bit = 0.

Function
- REQ-011: rx SHALL pass through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value (rx_s).
- REQ-012: Tick counter SHALL count 0..BAUD_DIV-1, pulsing tick for one clk at BAUD_DIV-1, then wrap to 0.
- REQ-013: Tick counter SHALL free-run in all states, including IDLE.
- REQ-014: FSM states SHALL be IDLE, START, DATA and STOP, with a 4-bit tick-in-bit counter and a 3-bit bit index.
- REQ-015: IDLE: rx_s = 0 SHALL move to START and clear the tick-in-bit counter.
- REQ-016: START: on the 8th tick, rx_s = 0 SHALL move to DATA and clear the counters; rx_s = 1 SHALL return to IDLE (glitch, no flag change).
- REQ-017: DATA: every 16th tick SHALL shift rx_s into bit[index], LSB first; after index 7, move to STOP.
- REQ-018: STOP, 16th tick, rx_s = 1, rx_ready = 0: load data_out, set rx_ready, go IDLE.
- REQ-019: STOP, 16th tick, rx_s = 1, rx_ready = 1: keep data_out unchanged, set overrun, go IDLE.
- REQ-020: STOP, 16th tick, rx_s = 0: discard the byte and set framing_err.
- REQ-021: After a framing error the FSM SHALL remain in STOP until rx_s = 1, then go IDLE (no restart on a held-low break).
- REQ-022: Flags SHALL assert on the clk edge following the stop-sample tick (latency 1 clk).
- REQ-023: A read (cs AND read_strobe) SHALL clear rx_ready, overrun and framing_err on the next edge; data_out holds its value.
- REQ-024: If a flag set and a read occur in the same cycle, the set SHALL win: the flag is 1 and data_out holds the new byte.
- REQ-025: read_strobe without cs SHALL have no effect.
- REQ-026: The flags SHALL be sticky until read or reset.

Reset
- REQ-027: reset SHALL force FSM = IDLE, all counters = 0, synchronizer = 1, data_out = 8'h00, rx_ready = 0, overrun = 0 and framing_err = 0.
- REQ-028: reset asserted mid-frame SHALL abort the frame with no flag or data_out update; reception restarts at the next falling edge after release.
- REQ-029: reset SHALL take priority over every other event in the same cycle.

Verification (BAUD_DIV = 4, so 64 clk per bit)
- REQ-030: Frame 0x55, valid stop -> data_out = 8'h55 and rx_ready = 1 on the clk after the stop-sample tick; overrun = 0, framing_err = 0.
- REQ-031: Frame 0xA3, then a read (cs = 1, read_strobe = 1) -> rx_ready = 0 next cycle; data_out stays 8'hA3.
- REQ-032: Frames 0x12 then 0x34 with no read between -> data_out = 8'h12, rx_ready = 1, overrun = 1; a read clears both flags.
- REQ-033: Frame 0xFF with stop bit = 0, rx held low 200 clk, then high -> framing_err = 1, rx_ready = 0, no new frame starts while low; a next valid 0x0F frame is received correctly.
- REQ-034: 20-clk low glitch on idle rx -> FSM returns to IDLE; no flag changes.
- REQ-035: reset pulse during bit 4 of a frame, then a clean 0xC6 frame -> all outputs 0 after reset; data_out = 8'hC6 and rx_ready = 1 for the second frame.
- REQ-036: Read issued in the same cycle rx_ready sets -> rx_ready stays 1 and data_out holds the new byte.

Source files
------------

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with a 16x oversampling tick and a processor read port.
// Flags assert one clk after the stop-sample tick and stay set until a read or reset.
module uart_rx_port #(
   parameter int BAUD_DIV = 326
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       cs,
   input  logic       read_strobe,
   output logic [7:0] data_out,
   output logic       rx_ready,
   output logic       overrun,
   output logic       framing_err
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] TICK_MAX = CW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic            rx_meta_q, rx_meta_d;
   logic            rx_s_q, rx_s_d;
   logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [3:0]      tib_q, tib_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            brk_q, brk_d;
   logic [7:0]      data_q, data_d;
   logic            rdy_q, rdy_d;
   logic            ovr_q, ovr_d;
   logic            ferr_q, ferr_d;
   logic            tick;
   logic            rd;

   always_comb begin
      state_d    = state_q;
      rx_meta_d  = rx;
      rx_s_d     = rx_meta_q;
      tick_cnt_d = tick_cnt_q;
      tib_d      = tib_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      brk_d      = brk_q;
      data_d     = data_q;
      rdy_d      = rdy_q;
      ovr_d      = ovr_q;
      ferr_d     = ferr_q;

      tick       = (tick_cnt_q == TICK_MAX);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

      // Clear first so a flag set later in this block wins over a same-cycle read.
      rd = cs & read_strobe;
      if (rd) begin
         rdy_d  = 1'b0;
         ovr_d  = 1'b0;
         ferr_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               tib_d   = 4'd0;
            end
         end
         START: begin
            if (tick) begin
               if (tib_q == 4'd7) begin
                  if (!rx_s_q) begin
                     state_d   = DATA;
                     tib_d     = 4'd0;
                     bit_idx_d = 3'd0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tib_d = tib_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               tib_d = tib_q + 4'd1;
               if (tib_q == 4'd15) begin
                  shift_d[bit_idx_q] = rx_s_q;
                  if (bit_idx_q == 3'd7) state_d = STOP;
                  else                   bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            // After a bad stop bit, wait for the line to go idle before re-arming.
            if (brk_q) begin
               if (rx_s_q) begin
                  state_d = IDLE;
                  brk_d   = 1'b0;
               end
            end else if (tick) begin
               tib_d = tib_q + 4'd1;
               if (tib_q == 4'd15) begin
                  if (rx_s_q) begin
                     if (rdy_q) begin
                        ovr_d = 1'b1;
                     end else begin
                        data_d = shift_q;
                        rdy_d  = 1'b1;
                     end
                     state_d = IDLE;
                  end else begin
                     ferr_d = 1'b1;
                     brk_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         tick_cnt_q <= '0;
         tib_q      <= 4'd0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         brk_q      <= 1'b0;
         data_q     <= 8'h00;
         rdy_q      <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx_meta_d;
         rx_s_q     <= rx_s_d;
         tick_cnt_q <= tick_cnt_d;
         tib_q      <= tib_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         brk_q      <= brk_d;
         data_q     <= data_d;
         rdy_q      <= rdy_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
      end
   end

   assign data_out    = data_q;
   assign rx_ready    = rdy_q;
   assign overrun     = ovr_q;
   assign framing_err = ferr_q;

endmodule
